// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// controller state encodings, Booth recoding ops and the default operand width.
package booth_pkg;

    localparam int unsigned BOOTH_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } op_t;

    // Radix-2 Booth recoding of the pair {Q[0], Q-1}.
    function automatic op_t booth_op(input logic q0, input logic q_m1);
        op_t op;
        case ({q0, q_m1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// (n+1)-bit shared adder/subtractor: x + y, or x - y computed as x + ~y + 1.
module booth_addsub
    import booth_pkg::*;
#(
    parameter int n = BOOTH_N
) (
    input  logic         sub,
    input  logic [n:0]   x,
    input  logic [n:0]   y,
    output logic [n:0]   sum
);

    logic [n:0] y_inv_s;
    logic [n:0] cin_s;

    // Conditional inversion plus carry-in; the carry-out falls off the top.
    assign y_inv_s = y ^ {(n + 1){sub}};
    assign cin_s   = {{n{1'b0}}, sub};
    assign sum     = x + y_inv_s + cin_s;

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: signed n x n -> signed 2n, one add/sub
// and one arithmetic shift per cycle, with a start/busy/done handshake.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int n = BOOTH_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*n-1:0]   product
);

    localparam int CW = $clog2(n) + 1;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [n:0]       a_r;
    logic [n:0]       m_r;
    logic [n-1:0]     q_r;
    logic             qm1_r;
    logic [CW-1:0]    cnt_r;

    op_t              op_s;
    logic             sub_s;
    logic [n:0]       sum_s;
    logic [n:0]       a_new_s;
    logic [2*n+1:0]   shift_s;

    assign op_s  = booth_op(q_r[0], qm1_r);
    assign sub_s = (op_s == OP_SUB);

    booth_addsub #(.n(n)) u_addsub (
        .sub (sub_s),
        .x   (a_r),
        .y   (m_r),
        .sum (sum_s)
    );

    // Select the Booth partial result, then shift {A_new, Q, Q-1} right arithmetically.
    always_comb begin
        a_new_s = a_r;
        case (op_s)
            OP_ADD, OP_SUB: a_new_s = sum_s;
            default:        a_new_s = a_r;
        endcase
        shift_s = {a_new_s[n], a_new_s, q_r};
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // A/Q/Q-1/M datapath, iteration counter and product register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            m_r     <= '0;
            q_r     <= '0;
            qm1_r   <= 1'b0;
            cnt_r   <= '0;
            product <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        m_r   <= {a[n-1], a};
                        q_r   <= b;
                        a_r   <= '0;
                        qm1_r <= 1'b0;
                        cnt_r <= CW'(n);
                    end
                end
                RUN: begin
                    a_r   <= shift_s[2*n+1:n+1];
                    q_r   <= shift_s[n:1];
                    qm1_r <= shift_s[0];
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        product <= shift_s[2*n:1];
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult with a product scoreboard.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    booth_seq_mult #(.n(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_in),
        .b       (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Pop the oldest expected product and compare with the DUT output.
    task automatic score(input string tag);
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            check({tag, "_product"}, product, exp_q.pop_front());
        end
    endtask

    // Called at the first negedge after the accepting edge; cyc counts edges since then.
    task automatic wait_done(input int limit, output int cyc, output int busy_cycles);
        cyc = 0;
        busy_cycles = 0;
        while (!done && cyc < limit) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] expv, input string tag);
        int cyc;
        int bc;
        @(negedge clk);
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        wait_done(40, cyc, bc);
        check({tag, "_latency"}, 64'(cyc), 64'd32);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd32);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        score(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int bc;
        int n_done;
        int hold_bad;
        int k;
        int t;
        int last;
        logic [31:0] x;
        logic [31:0] y;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, "small");
        run_op(32'h80000000, 32'h80000000, 64'h4000000000000000, "min_sq");
        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, "max_sq");
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom;
            run_op(x, y, ref_mul(x, y), "rand");
        end

        // Second request pulsed mid-run must be dropped.
        @(negedge clk);
        a_in = 32'd6;
        b_in = 32'd7;
        start = 1'b1;
        exp_q.push_back(64'd42);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a_in = 32'd2;
        b_in = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, cyc, bc);
        check("ignored_latency", 64'(cyc), 64'd26);
        score("ignored");
        n_done = 0;
        hold_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (product !== 64'd42) hold_bad++;
        end
        check("ignored_no_second_done", 64'(n_done), 64'd0);
        check("ignored_product_hold", 64'(hold_bad), 64'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        a_in = 32'hFFFFFFFF;
        b_in = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", product, 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        run_op(32'hFFFFFFFC, 32'hFFFFFFFC, 64'd16, "after_rst");

        // Back-to-back with start held high.
        exp_q.push_back(64'd1);
        exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
        exp_q.push_back(64'd0);
        @(negedge clk);
        a_in = 32'd1;
        b_in = 32'd1;
        start = 1'b1;
        k = 0;
        t = 0;
        last = 0;
        while (k < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (done) begin
                score("b2b");
                if (k > 0) check("b2b_spacing", 64'(t - last), 64'd34);
                last = t;
                k++;
                case (k)
                    1: begin a_in = 32'hFFFFFFFF; b_in = 32'd1; end
                    2: begin a_in = 32'd0; b_in = 32'd123; end
                    default: start = 1'b0;
                endcase
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(k), 64'd3);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
